// File: rtl/quadra_pipe_pkg.sv
// quadra_pipe_pkg: widths, stage types, rounding modes and saturation limits for quadra_pipe
package quadra_pipe_pkg;
  localparam int SEG_W = 7;
  localparam int X2_W = 17;
  localparam int A_W = 26;
  localparam int B_W = 20;
  localparam int C_W = 14;
  localparam int Y_W = 24;
  localparam int Y_SHIFT = 34;
  localparam int X_W = SEG_W + X2_W;
  localparam int SQ_W = 2 * X2_W;
  localparam int P1_W = B_W + X2_W + 1;
  localparam int P2_W = C_W + SQ_W + 1;
  // The A term is the widest; two guard bits absorb the carries of the three-way sum
  localparam int SUM_W = A_W + SQ_W + 2;
  localparam int Q_W = SUM_W - Y_SHIFT;
  localparam int QR_W = Q_W + 1;
  localparam logic [Y_SHIFT-1:0] HALF = {1'b1, {(Y_SHIFT-1){1'b0}}};
  localparam logic signed [Y_W-1:0] Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0] Y_MIN = {1'b1, {(Y_W-1){1'b0}}};
  localparam logic signed [QR_W-1:0] QR_MAX = QR_W'(Y_MAX);
  localparam logic signed [QR_W-1:0] QR_MIN = QR_W'(Y_MIN);

  typedef enum logic {RM_RNE = 1'b0, RM_TRUNC = 1'b1} rmode_e;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } coef_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    rmode_e rm;
  } s0_t;

  typedef struct packed {
    coef_t cf;
    logic [X2_W-1:0] x2;
    logic [SQ_W-1:0] sq;
    rmode_e rm;
  } s1_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [P1_W-1:0] p1;
    logic [P2_W-1:0] p2;
    rmode_e rm;
  } s2_t;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic sat;
  } s3_t;

  // Quotient is one bit wider than needed so the round-up increment cannot wrap
  function automatic s3_t round_sat(input logic signed [SUM_W-1:0] s, input rmode_e rm);
    logic [Q_W-1:0] q;
    logic [Y_SHIFT-1:0] r;
    logic inc;
    logic signed [QR_W-1:0] qr;
    s3_t o;
    q = s[SUM_W-1:Y_SHIFT];
    r = s[Y_SHIFT-1:0];
    inc = (rm == RM_RNE) && ((r > HALF) || ((r == HALF) && q[0]));
    qr = {q[Q_W-1], q} + QR_W'(inc);
    o.sat = (qr > QR_MAX) || (qr < QR_MIN);
    o.y = (qr > QR_MAX) ? Y_MAX : (qr < QR_MIN) ? Y_MIN : qr[Y_W-1:0];
    return o;
  endfunction
endpackage

// File: rtl/quadra_pipe_coef_rf.sv
// quadra_coef_rf: per-segment coefficient register file, one write port and one combinational read port
module quadra_coef_rf
  import quadra_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             we_i,
  input  logic [SEG_W-1:0] waddr_i,
  input  coef_t            wdata_i,
  input  logic [SEG_W-1:0] raddr_i,
  output coef_t            rdata_o
);
  coef_t mem_q [2**SEG_W];

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) for (int i = 0; i < 2**SEG_W; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/quadra_pipe.sv
// quadra_pipe: handshaked four-stage piecewise-quadratic evaluator with per-sample rounding and saturation
module quadra_pipe
  import quadra_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic             in_rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Y_W-1:0]   out_y,
  output logic             out_sat,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [A_W-1:0]   cfg_a,
  input  logic [B_W-1:0]   cfg_b,
  input  logic [C_W-1:0]   cfg_c
);
  logic adv;
  logic [2:0] v_q;
  logic out_valid_q;
  s0_t s0_q, s0_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  coef_t wcf, rcf;
  logic [X2_W-1:0] x2;
  logic signed [P1_W-1:0] p1;
  logic signed [P2_W-1:0] p2;
  logic signed [SUM_W-1:0] sum;

  assign adv = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign wcf = {cfg_a, cfg_b, cfg_c};

  quadra_coef_rf u_rf (
    .clk(clk),
    .rst_b(rst_b),
    .we_i(cfg_we),
    .waddr_i(cfg_addr),
    .wdata_i(wcf),
    .raddr_i(s0_q.x[X_W-1:X2_W]),
    .rdata_o(rcf)
  );

  assign s0_d = '{x: in_x, rm: rmode_e'(in_rmode)};

  assign x2 = s0_q.x[X2_W-1:0];
  assign s1_d = '{cf: rcf, x2: x2, sq: SQ_W'(x2) * SQ_W'(x2), rm: s0_q.rm};

  assign p1 = P1_W'($signed(s1_q.cf.b)) * P1_W'($signed({1'b0, s1_q.x2}));
  assign p2 = P2_W'($signed(s1_q.cf.c)) * P2_W'($signed({1'b0, s1_q.sq}));
  assign s2_d = '{a: s1_q.cf.a, p1: p1, p2: p2, rm: s1_q.rm};

  assign sum = (SUM_W'($signed(s2_q.a)) <<< SQ_W)
             + (SUM_W'($signed(s2_q.p1)) <<< X2_W)
             + SUM_W'($signed(s2_q.p2));
  assign s3_d = round_sat(sum, s2_q.rm);

  // Output register only updates on a real sample so out_y stays clean across bubbles
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      v_q <= '0;
      out_valid_q <= 1'b0;
      s3_q <= '0;
    end else if (adv) begin
      v_q <= {v_q[1:0], in_valid};
      out_valid_q <= v_q[2];
      if (v_q[2]) s3_q <= s3_d;
    end

  always_ff @(posedge clk)
    if (adv) begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end

  assign out_valid = out_valid_q;
  assign out_y = s3_q.y;
  assign out_sat = s3_q.sat;
endmodule

// File: tb/tb_quadra_pipe.sv
// tb_quadra_pipe: directed vectors with hand-computed results for quadra_pipe
module tb_quadra_pipe;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic in_valid, in_ready, in_rmode, out_valid, out_ready, out_sat, cfg_we;
  logic [23:0] in_x, out_y;
  logic [6:0] cfg_addr;
  logic [25:0] cfg_a;
  logic [19:0] cfg_b;
  logic [13:0] cfg_c;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quadra_pipe dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_rmode(in_rmode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] seg, input logic [25:0] a, input logic [19:0] b, input logic [13:0] c);
    cfg_we = 1'b1; cfg_addr = seg; cfg_a = a; cfg_b = b; cfg_c = c;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [6:0] seg, input logic [16:0] x2,
                         input logic rm, input logic [23:0] ey, input logic es);
    in_valid = 1'b1; in_x = {seg, x2}; in_rmode = rm;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_y"}, out_y, ey);
    check({tag, "_sat"}, out_sat, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, rx;
    logic acc;
    logic [23:0] hold;
    in_valid = 0; in_x = 0; in_rmode = 0; out_ready = 1;
    cfg_we = 0; cfg_addr = 0; cfg_a = 0; cfg_b = 0; cfg_c = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_y", out_y, 0);
    check("rst_sat", out_sat, 0);
    check("rst_ready", in_ready, 1);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();

    wr(3, 26'd5, 0, 0);
    run_one("ident", 3, 17'd12345, 0, 24'd5, 0);
    wr(0, 0, 20'd1, 0);
    run_one("tie_rne", 0, 17'd65536, 0, 24'd0, 0);
    run_one("tie_tr", 0, 17'd65536, 1, 24'd0, 0);
    wr(0, 26'd1, 20'd1, 0);
    run_one("tie1_rne", 0, 17'd65536, 0, 24'd2, 0);
    run_one("tie1_tr", 0, 17'd65536, 1, 24'd1, 0);
    wr(1, 0, 0, 14'd1);
    run_one("c_rne", 1, 17'h1FFFF, 0, 24'd1, 0);
    run_one("c_tr", 1, 17'h1FFFF, 1, 24'd0, 0);
    wr(4, 26'h1FFFFFF, 20'h7FFFF, 14'h1FFF);
    run_one("sat_hi", 4, 17'h1FFFF, 0, 24'h7FFFFF, 1);
    wr(5, 26'h2000000, 20'h80000, 0);
    run_one("sat_lo", 5, 17'h1FFFF, 0, 24'h800000, 1);
    wr(6, 26'h3FFFFFE, 20'hFFFFF, 0);
    run_one("neg_rne", 6, 17'd65536, 0, 24'hFFFFFE, 0);
    run_one("neg_tr", 6, 17'd65536, 1, 24'hFFFFFD, 0);
    wr(7, 0, 20'hFFF9C, 0);
    run_one("b_rne", 7, 17'd1311, 0, 24'hFFFFFF, 0);
    run_one("b_tr", 7, 17'd1311, 1, 24'hFFFFFE, 0);

    in_valid = 1; in_x = {7'd0, 17'd65536}; in_rmode = 0;
    tick();
    in_rmode = 1;
    tick();
    in_valid = 0;
    repeat (2) tick();
    check("rm_seq0_v", out_valid, 1);
    check("rm_seq0_y", out_y, 24'd2);
    tick();
    check("rm_seq1_v", out_valid, 1);
    check("rm_seq1_y", out_y, 24'd1);

    wr(2, 26'd4, 0, 0);
    in_valid = 1; in_x = {7'd2, 17'd100}; in_rmode = 0;
    tick();
    cfg_we = 1; cfg_addr = 2; cfg_a = 26'd7; cfg_b = 0; cfg_c = 0;
    tick();
    in_valid = 0; cfg_we = 0;
    repeat (2) tick();
    check("hz_old_v", out_valid, 1);
    check("hz_old_y", out_y, 24'd4);
    tick();
    check("hz_new_v", out_valid, 1);
    check("hz_new_y", out_y, 24'd7);

    for (int i = 0; i < 10; i++) wr(7'(10 + i), 26'((i + 1) * 3), 0, 0);
    sent = 0; rx = 0; hold = '0;
    for (int c = 0; c < 40 && rx < 10; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid = sent < 10;
      in_x = {7'(10 + sent), 17'(sent * 977)};
      in_rmode = sent[0];
      #1;
      if (c >= 6 && c <= 9) begin
        check("bp_stall_v", out_valid, 1);
        check("bp_ready", in_ready, 0);
        if (c == 6) hold = out_y;
        else check("bp_hold", out_y, hold);
      end
      if (out_valid && out_ready) begin
        check("bp_data", out_y, 24'((rx + 1) * 3));
        rx++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    check("bp_count", rx, 10);
    out_ready = 1; in_valid = 0;
    tick();
    check("bp_drain", out_valid, 0);

    wr(9, 26'd11, 0, 0);
    in_valid = 1; in_x = {7'd9, 17'd5}; in_rmode = 0;
    repeat (4) tick();
    in_valid = 0;
    check("rs_pre_v", out_valid, 1);
    check("rs_pre_y", out_y, 24'd11);
    #1 rst_b = 0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_y", out_y, 0);
    #1 rst_b = 1;
    repeat (6) begin
      tick();
      check("rs_idle", out_valid, 0);
    end
    run_one("rs_tbl", 9, 17'd5, 0, 24'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quadra_pipe.md
Name: quadra_pipe

Overview:
Parametrised, handshaked successor of the piecewise-quadratic evaluator: y = round((A<<2F) + (B*x2<<F) + C*x2^2) >> Y_SHIFT), with F = X2_W.
- Coefficient table is a run-time-writable register file, not a fixed LUT.
- Rounding mode is selected per sample; output saturates to Y_W signed.
- Sits between a valid/ready producer and consumer in the function-generator datapath.

Parameters:
SEG_W, 7, segment index bits (table depth 2^SEG_W)
X2_W, 17, unsigned fractional offset bits within segment
A_W, 26, signed width of coefficient A
B_W, 20, signed width of coefficient B
C_W, 14, signed width of coefficient C
Y_W, 24, signed output width
Y_SHIFT, 34, right shift applied to the full-precision sum before rounding

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_x  in  SEG_W+X2_W  {segment, x2}, segment = MSBs
in_rmode  in  1  0 = round-half-to-even, 1 = truncate toward -inf
out_valid  out  1  output sample valid
out_ready  in  1  consumer accepts output
out_y  out  Y_W  signed result
out_sat  out  1  result was clipped
cfg_we  in  1  coefficient write strobe
cfg_addr  in  SEG_W  segment to write
cfg_a  in  A_W  coefficient A
cfg_b  in  B_W  coefficient B
cfg_c  in  C_W  coefficient C

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits, out_valid, out_y and out_sat clear to 0.
  - Coefficient table clears to 0.
  - Datapath registers are not reset.
- Pipeline: 4 register stages S0..S3.
  - S0: capture x and rmode.
  - S1: table read, x2^2.
  - S2: products B*x2 and C*x2^2.
  - S3: sum, round, saturate; S3 is the output register.
- Global advance = !out_valid || out_ready; in_ready = advance (combinational).
  - On advance, every stage shifts and its valid bit follows.
  - Without advance, all stages hold.
  - Sample accepted iff in_valid && in_ready.
- Latency: 4 cycles, acceptance edge to out_valid. Throughput: 1/cycle while out_ready stays high.
- out_y/out_sat are stable while out_valid && !out_ready.
- Arithmetic (signed, full precision, no intermediate truncation):
  - x2 is zero-extended.
  - s = (A << 2*X2_W) + (B*x2 << X2_W) + C*x2*x2.
  - Sum width must hold every term without overflow.
  - q = s >>> Y_SHIFT, remainder r = s[Y_SHIFT-1:0].
  - rmode 0: add 1 if r > half, or r == half and q is odd.
  - rmode 1: q unchanged.
  - Saturate to [-2^(Y_W-1), 2^(Y_W-1)-1]; out_sat = 1 when clipped.
- rmode travels with its sample; a mode change mid-stream affects only later samples.
- Config writes:
  - Any cycle, independent of the handshake.
  - Take effect at the next clk edge.
  - An S1 read of the same address in the write cycle returns the old value.
- Reset mid-stream: in-flight samples are discarded; no out_valid until new inputs arrive.

Decomposition:
- Package quadra_pipe_pkg holds:
  - Derived widths (X_W, SQ_W, P1_W, P2_W, SUM_W).
  - typedefs coef_t (A/B/C struct), stage structs s0_t..s3_t.
  - Rounding-mode enum RM_RNE/RM_TRUNC.
  - Saturation limit constants.
- Sub-module quadra_coef_rf: 2^SEG_W-entry register file with async reset, one write port, one combinational read port.

Test Plan:
- Identity: seg 3 with A=5, B=0, C=0; in_x={3,x2=12345}, rmode 0 -> out_y=5 exactly 4 cycles after acceptance, out_sat=0.
- Tie rounding: seg 0 A=0, B=1, C=0, x2=65536 gives 0.5 LSB -> rmode 0 yields 0, rmode 1 yields 0. With A=1 (1.5 LSB) -> rmode 0 yields 2, rmode 1 yields 1.
- Saturation:
  - A=2^25-1, B=2^19-1, C=2^13-1, x2=131071 -> out_y=0x7FFFFF, out_sat=1.
  - A=-2^25, B=-2^19, C=0, x2=131071 -> out_y=0x800000, out_sat=1.
- Backpressure: stream 10 samples, out_ready=0 for cycles 6-9.
  - in_ready low while the output is stalled.
  - out_y held during the stall.
  - All 10 results arrive in order, none lost or duplicated.
- Config hazard: write seg 2 A=7 in the same cycle a seg-2 sample sits in S1 (old A=4, B=C=0) -> that sample gives 4, the next gives 7.
- Async reset: assert rst_b mid-stream with 3 samples in flight, no clk edge -> out_valid=0 and out_y=0 immediately. After release -> no output until a new sample has waited 4 cycles; table reads back 0.
